// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream into and reordered stream out of fft_bitrev_reorder, plus the realignment flag.
// The slave side is the reorder block; the master side is whoever feeds it and consumes its output.
interface fft_bitrev_reorder_if #(
   parameter int WIDTH = 24
);
   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic             in_sof;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_sof;
   logic             sync_err;

   modport master (
      output in, in_valid, in_sof,
      input  out, out_valid, out_sof, sync_err
   );

   modport slave (
      input  in, in_valid, in_sof,
      output out, out_valid, out_sof, sync_err
   );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Re-emits bit-reversed FFT frames in natural bin order using ping-pong N-entry banks.
// Bin k leaves k+1 cycles after a frame's last accepted sample; no backpressure in either direction.
module fft_bitrev_reorder #(
   parameter int WIDTH = 24,
   parameter int LOG2N = 6
) (
   input logic                 clk,
   input logic                 reset,
   fft_bitrev_reorder_if.slave bus
);
   localparam int N = 1 << LOG2N;

   typedef logic [LOG2N-1:0] addr_t;
   typedef enum logic {IDLE, DRAIN} rd_state_e;

   logic [WIDTH-1:0] mem_q [0:1][0:N-1];

   addr_t            wr_cnt_q, wr_cnt_d;
   addr_t            rd_cnt_q, rd_cnt_d;
   addr_t            wr_addr;
   logic             wr_en;
   logic             frame_done;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   rd_state_e        state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sof_q, out_sof_d;
   logic             sync_err_q, sync_err_d;

   function automatic addr_t bitrev(input addr_t a);
      addr_t r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      sync_err_d  = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = bitrev(wr_cnt_q);
      frame_done  = 1'b0;

      if (bus.in_valid) begin
         wr_en = 1'b1;
         // An early start-of-frame throws away the partial frame and restarts at bin 0.
         if (bus.in_sof && (wr_cnt_q != '0)) begin
            wr_addr    = '0;
            wr_cnt_d   = addr_t'(1);
            sync_err_d = 1'b1;
         end else begin
            wr_cnt_d   = wr_cnt_q + 1'b1;
            frame_done = (wr_cnt_q == addr_t'(N-1));
         end
      end

      if (frame_done) wr_bank_d = ~wr_bank_q;

      case (state_q)
         IDLE: begin
            if (frame_done) begin
               state_d   = DRAIN;
               rd_cnt_d  = '0;
               rd_bank_d = wr_bank_q;
            end
         end
         DRAIN: begin
            out_d       = mem_q[rd_bank_q][rd_cnt_q];
            out_valid_d = 1'b1;
            out_sof_d   = (rd_cnt_q == '0);
            rd_cnt_d    = rd_cnt_q + 1'b1;
            // A frame finishing on the last drain edge chains straight into the next drain.
            if (rd_cnt_q == addr_t'(N-1)) begin
               if (frame_done) rd_bank_d = wr_bank_q;
               else            state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_bank_q][wr_addr] <= bus.in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         state_q     <= IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.sync_err  = sync_err_q;
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Downstream stage of top_FFT.
- Consumes the FFT's 24-bit complex stream ({re[23:12], im[11:0]}), which arrives in bit-reversed bin order, and re-emits each frame in natural bin order.
- Uses a ping-pong pair of N-entry buffers so that continuous input produces continuous output.
- Feeds the post-FFT magnitude/peak stages.

Parameters:
- WIDTH, 24: sample width; passed through untouched.
- LOG2N, 6: log2 of frame length; N = 2**LOG2N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in  input  WIDTH  FFT output sample.
- in_valid  input  1  "in" is accepted on this edge.
- in_sof  input  1  start of frame; qualified by in_valid.
- out  output  WIDTH  reordered sample.
- out_valid  output  1  "out" holds a valid natural-order sample.
- out_sof  output  1  high with bin 0 of each output frame.
- sync_err  output  1  one-cycle pulse: a frame was truncated by in_sof.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, named reset. Asserting reset=0 immediately clears all state.
- Reset values: out=0, out_valid=0, out_sof=0, sync_err=0; wr_cnt=0, rd_cnt=0, wr_bank=0, read state=IDLE. Buffer contents are don't-care.
- Write side:
  - On each edge with in_valid=1, store "in" at wr_bank[bitrev(wr_cnt)], where bitrev reverses the LOG2N address bits, then increment wr_cnt (mod N).
  - in_valid=0: nothing is written and wr_cnt holds.
- Frame completion: an accepted sample with wr_cnt=N-1 completes the frame. On that edge:
  - wr_cnt wraps to 0.
  - wr_bank toggles.
  - The completed bank is handed to the read side as rd_bank.
- in_sof realignment:
  - in_valid=1, in_sof=1, wr_cnt!=0: discard the partial frame, write the sample at address 0, set wr_cnt=1, pulse sync_err for one cycle.
  - in_sof with wr_cnt=0: normal; no sync_err.
  - in_sof without in_valid: ignored.
  - No sync_err is raised for a missing in_sof.
- Read FSM, IDLE / DRAIN:
  - IDLE -> DRAIN on a frame-completion edge: rd_cnt=0, rd_bank latched.
  - In DRAIN, every edge registers out = rd_bank[rd_cnt] and out_valid=1; out_sof=1 only when rd_cnt=0; then rd_cnt increments.
  - After rd_cnt=N-1 is emitted: if a frame completed on that same edge, restart DRAIN at rd_cnt=0 on the new bank (no bubble); otherwise go to IDLE with out_valid=0 and out holding its last value.
  - No backpressure.
- Latency: if the last sample of a frame is accepted at edge E, bin k appears on "out" at edge E+1+k.
- Overlap safety: a frame needs at least N accept edges and a drain takes exactly N edges, so the read bank is never overwritten.
- Full-rate operation: with continuous input at 1 sample/cycle, out_valid stays high continuously once the first frame is done.
- Gapped input: output is bursty, with N contiguous samples per frame.
- Reset mid-frame or mid-drain: partial input and any undrained output are dropped; outputs return to reset values immediately.
- Arithmetic: data is not modified; only the address counters are LOG2N-bit with natural wrap-around.

Test Plan:
- LOG2N=3, reset released, then 8 continuous valid samples 0..7 with in_sof on the first -> one cycle after the last input, out = 0,4,2,6,1,5,3,7 on consecutive cycles; out_sof with the first; out_valid high for exactly 8 cycles.
- LOG2N=3, 3 back-to-back frames (values 0..23) -> 24 contiguous out_valid cycles; frame f outputs 8f + bitrev(k); out_sof at outputs 0, 8, 16.
- LOG2N=3, in_valid toggling 1-0-1-0 over one frame -> no output until the 8th accept; then 8 contiguous outputs in bitrev order.
- LOG2N=3, send 5 samples, then in_sof with value 100 followed by 7 more (101..107) -> sync_err pulses once; output frame is 100,104,102,106,101,105,103,107.
- LOG2N=6, reset driven low during output bin 20 -> out_valid=0 and out=0 asynchronously; after release, a fresh 64-sample frame reorders correctly.
- LOG2N=6, 16 frames of FFT-like random data (1024 samples at 1/cycle) -> every output equals the golden natural-order value; error count 0.
